mc_main_fsm: RTL
================

// Module: mc_main_fsm
// PURPOSE
//   Multicycle MIPS main controller: replaces the single-cycle opcode decoder with a
//   Moore FSM (plus ready-gated strobes) that sequences fetch/decode/execute/mem/writeback.
//   Sits between the instruction register (opcode) and the shared-memory multicycle datapath.
//   Adds a memory wait-state handshake, optional BNE/JAL, an illegal-op trap and a retire counter.
// PARAMETERS
//   EN_BNE      1   1: opcode 000101 decoded as BNE; 0: treated as illegal
//   EN_JAL      1   1: opcode 000011 decoded as JAL; 0: treated as illegal
//   EN_WAIT     1   1: memory states hold until mem_ready_i; 0: mem_ready_i ignored (taken as 1)
//   TRAP_STICKY 1   1: illegal op parks FSM in TRAP until reset; 0: flag pulse, resume FETCH
//   CNT_W       32  width of retired-instruction counter
// PORTS
//   clk_i          in   1      clock, all state updates on rising edge
//   rst_i          in   1      synchronous, active-high reset
//   op_i6          in   6      opcode from instruction register (valid from DECODE onward)
//   mem_ready_i    in   1      memory completes current access this cycle
//   mem_req_o      out  1      memory access in progress (FETCH, MEMREAD, MEMWRITE)
//   mem_write_o    out  1      write strobe for data access (MEMWRITE)
//   iord_o         out  1      0: address=PC, 1: address=ALUOut
//   ir_write_o     out  1      load instruction register
//   pc_write_o     out  1      unconditional PC load
//   branch_o       out  1      PC load if ALU zero (BEQ)
//   branch_ne_o    out  1      PC load if ALU not zero (BNE)
//   reg_write_o    out  1      register file write enable
//   reg_dst_o2     out  2      00 rt, 01 rd, 10 $ra (31)
//   mem_to_reg_o2  out  2      00 ALUOut, 01 data reg, 10 PC
//   alu_src_a_o    out  1      0 PC, 1 register A
//   alu_src_b_o2   out  2      00 B, 01 const 4, 10 signimm, 11 signimm<<2
//   alu_op_o2      out  2      00 add, 01 sub, 10 funct-decoded
//   pc_src_o2      out  2      00 ALU result, 01 ALUOut, 10 jump target
//   illegal_o      out  1      illegal opcode detected
//   state_o4       out  4      current state encoding (debug)
//   retired_o      out  CNT_W  count of completed instructions
// BEHAVIOUR
//   States: FETCH=0 DECODE=1 MEMADR=2 MEMREAD=3 MEMWB=4 MEMWRITE=5 EXECUTE=6 ALUWB=7
//     BRANCH=8 ADDIEXE=9 ADDIWB=10 JUMP=11 JAL=12 TRAP=15.
//   Reset: state=FETCH, retired_o=0, illegal_o=0; all other outputs follow FETCH decode.
//   Unlisted outputs are 0 in every state; no x values driven.
//   FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00;
//     ir_write=pc_write=mem_ready (combinational gate); stay until ready, then DECODE.
//   DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next by op_i6: 100011/101011->MEMADR,
//     000000->EXECUTE, 000100->BRANCH, 000101->BRANCH (EN_BNE), 001000->ADDIEXE,
//     000010->JUMP, 000011->JAL (EN_JAL), else illegal.
//   MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; LW->MEMREAD, SW->MEMWRITE.
//   MEMREAD: mem_req=1, iord=1; hold until ready -> MEMWB.
//   MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01 -> FETCH.
//   MEMWRITE: mem_req=1, iord=1, mem_write=1 held while waiting; ready -> FETCH.
//   EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB (reg_write, reg_dst=01) -> FETCH.
//   BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01; branch=1 for BEQ,
//     branch_ne=1 for BNE (opcode latched in DECODE, never both) -> FETCH.
//   ADDIEXE: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB (reg_write, reg_dst=00) -> FETCH.
//   JUMP: pc_write=1, pc_src=10 -> FETCH.
//   JAL: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10 -> FETCH.
//   Illegal: TRAP_STICKY=1 -> TRAP (illegal_o=1, all writes 0, only reset exits);
//     TRAP_STICKY=0 -> FETCH, illegal_o high for exactly one cycle; not counted as retired.
//   retired_o += 1 on each transition into FETCH from a non-reset, non-illegal path;
//     wraps modulo 2^CNT_W.
//   EN_WAIT=0: every memory state lasts exactly one cycle.
//   rst_i overrides everything, including mid-wait; outputs take FETCH values next cycle.
// TESTING
//   Reset, then R-type (op 0), ready=1 -> FETCH,DECODE,EXECUTE,ALUWB,FETCH; retired_o=1.
//   LW with mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, ir/pc_write=0; MEMWB once.
//   SW -> mem_write_o=1 for all MEMWRITE cycles incl. waits; reg_write_o never asserted.
//   BEQ then BNE -> BRANCH asserts branch_o then branch_ne_o, one cycle each, never together.
//   op=111111, TRAP_STICKY=1 -> TRAP, illegal_o=1 until rst_i; retired_o unchanged.
//   JAL (EN_JAL=1) -> one cycle with pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10.

Source files
------------

// File: rtl/mc_main_fsm_if.sv
// Purpose : controller <-> datapath/memory signal bundle for the multicycle MIPS main FSM.
// Latency : pure wiring, no state.
// Backpressure: mem_ready_i from memory stretches memory states; all other signals are strobes.
// Ports   : op_i6/mem_ready_i flow into the controller (master); all *_o controls flow out.
interface mc_main_fsm_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       op_i6;
   logic             mem_ready_i;
   logic             mem_req_o;
   logic             mem_write_o;
   logic             iord_o;
   logic             ir_write_o;
   logic             pc_write_o;
   logic             branch_o;
   logic             branch_ne_o;
   logic             reg_write_o;
   logic [1:0]       reg_dst_o2;
   logic [1:0]       mem_to_reg_o2;
   logic             alu_src_a_o;
   logic [1:0]       alu_src_b_o2;
   logic [1:0]       alu_op_o2;
   logic [1:0]       pc_src_o2;
   logic             illegal_o;
   logic [3:0]       state_o4;
   logic [CNT_W-1:0] retired_o;

   // Controller side.
   modport master (
      input  op_i6, mem_ready_i,
      output mem_req_o, mem_write_o, iord_o, ir_write_o, pc_write_o,
             branch_o, branch_ne_o, reg_write_o, reg_dst_o2, mem_to_reg_o2,
             alu_src_a_o, alu_src_b_o2, alu_op_o2, pc_src_o2,
             illegal_o, state_o4, retired_o
   );

   // Datapath / memory side.
   modport slave (
      output op_i6, mem_ready_i,
      input  mem_req_o, mem_write_o, iord_o, ir_write_o, pc_write_o,
             branch_o, branch_ne_o, reg_write_o, reg_dst_o2, mem_to_reg_o2,
             alu_src_a_o, alu_src_b_o2, alu_op_o2, pc_src_o2,
             illegal_o, state_o4, retired_o
   );
endinterface

// File: rtl/mc_main_fsm.sv
// Purpose : Moore main controller sequencing fetch/decode/execute/mem/writeback for a multicycle MIPS.
// Latency : one state per clock; controls are decoded from the current state (FETCH writes gated by mem_ready).
// Backpressure: FETCH/MEMREAD/MEMWRITE hold while mem_ready_i is low (when EN_WAIT), outputs stay stable.
// Ports   : clk_i/rst_i (sync, active-high); bus.master carries opcode, mem_ready and all datapath
//           controls, plus illegal_o trap flag, state_o4 debug state and retired_o instruction count.
module mc_main_fsm #(
   parameter int EN_BNE      = 1,
   parameter int EN_JAL      = 1,
   parameter int EN_WAIT     = 1,
   parameter int TRAP_STICKY = 1,
   parameter int CNT_W       = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   mc_main_fsm_if.master bus
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEXE  = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JUMP     = 4'd11,
      S_JAL      = 4'd12,
      S_TRAP     = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   state_t           state, state_n;
   logic [5:0]       op_q;          // opcode captured in DECODE, used by MEMADR/BRANCH
   logic [CNT_W-1:0] retired_q;
   logic             illegal_q;
   logic             ready;
   logic             retire;
   logic             illegal_det;

   logic       mem_req, mem_write, iord, ir_write, pc_write;
   logic       branch, branch_ne, reg_write, alu_src_a;
   logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_src;

   // Without wait states the memory is assumed to answer every cycle.
   assign ready = (EN_WAIT == 0) ? 1'b1 : bus.mem_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= S_FETCH;
         op_q      <= 6'd0;
         retired_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         state <= state_n;
         if (state == S_DECODE) begin
            op_q <= bus.op_i6;
         end
         if (retire) begin
            retired_q <= retired_q + CNT_W'(1);
         end
         // Sticky: flag stays with the TRAP state; otherwise a one-cycle pulse.
         if (TRAP_STICKY != 0) begin
            illegal_q <= illegal_q | illegal_det;
         end else begin
            illegal_q <= illegal_det;
         end
      end
   end

   always_comb begin
      state_n     = state;
      retire      = 1'b0;
      illegal_det = 1'b0;
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      iord        = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      branch      = 1'b0;
      branch_ne   = 1'b0;
      reg_write   = 1'b0;
      reg_dst     = 2'b00;
      mem_to_reg  = 2'b00;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      alu_op      = 2'b00;
      pc_src      = 2'b00;

      case (state)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'b01;
            // IR and PC load only in the cycle memory actually returns the word.
            ir_write  = ready;
            pc_write  = ready;
            if (ready) state_n = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;     // PC + (signimm<<2): speculative branch target
            case (bus.op_i6)
               OP_LW, OP_SW: state_n = S_MEMADR;
               OP_RTYPE:     state_n = S_EXECUTE;
               OP_BEQ:       state_n = S_BRANCH;
               OP_ADDI:      state_n = S_ADDIEXE;
               OP_J:         state_n = S_JUMP;
               OP_BNE: begin
                  if (EN_BNE != 0) state_n = S_BRANCH;
                  else             illegal_det = 1'b1;
               end
               OP_JAL: begin
                  if (EN_JAL != 0) state_n = S_JAL;
                  else             illegal_det = 1'b1;
               end
               default:      illegal_det = 1'b1;
            endcase
            if (illegal_det) begin
               state_n = (TRAP_STICKY != 0) ? S_TRAP : S_FETCH;
            end
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_n   = (op_q == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (ready) state_n = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 2'b01;
            state_n    = S_FETCH;
            retire     = 1'b1;
         end
         S_MEMWRITE: begin
            mem_req   = 1'b1;
            iord      = 1'b1;
            mem_write = 1'b1;
            if (ready) begin
               state_n = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_n   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 2'b01;
            state_n   = S_FETCH;
            retire    = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_src    = 2'b01;
            branch    = (op_q == OP_BEQ);
            branch_ne = (op_q == OP_BNE);
            state_n   = S_FETCH;
            retire    = 1'b1;
         end
         S_ADDIEXE: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_n   = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
            state_n   = S_FETCH;
            retire    = 1'b1;
         end
         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            state_n  = S_FETCH;
            retire   = 1'b1;
         end
         S_JAL: begin
            pc_write   = 1'b1;
            pc_src     = 2'b10;
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
            state_n    = S_FETCH;
            retire     = 1'b1;
         end
         S_TRAP: begin
            state_n = S_TRAP;  // only reset leaves
         end
         default: begin
            state_n = S_FETCH;
         end
      endcase
   end

   assign bus.mem_req_o     = mem_req;
   assign bus.mem_write_o   = mem_write;
   assign bus.iord_o        = iord;
   assign bus.ir_write_o    = ir_write;
   assign bus.pc_write_o    = pc_write;
   assign bus.branch_o      = branch;
   assign bus.branch_ne_o   = branch_ne;
   assign bus.reg_write_o   = reg_write;
   assign bus.reg_dst_o2    = reg_dst;
   assign bus.mem_to_reg_o2 = mem_to_reg;
   assign bus.alu_src_a_o   = alu_src_a;
   assign bus.alu_src_b_o2  = alu_src_b;
   assign bus.alu_op_o2     = alu_op;
   assign bus.pc_src_o2     = pc_src;
   assign bus.illegal_o     = illegal_q;
   assign bus.state_o4      = state;
   assign bus.retired_o     = retired_q;

endmodule
